// File: rtl/cpu_alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Define CPU_ALU_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module cpu_alu_arbiter (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [3:0]  i_req0_op,
  input  logic [31:0] i_req0_op1,
  input  logic [31:0] i_req0_op2,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [3:0]  i_req1_op,
  input  logic [31:0] i_req1_op1,
  input  logic [31:0] i_req1_op2,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_result,
  output logic [31:0] o_rsp0_shift_result,
  output logic        o_rsp0_compare,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_result,
  output logic [31:0] o_rsp1_shift_result,
  output logic        o_rsp1_compare,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_alu_op1,
  output logic [31:0] o_alu_op2,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_alu_shift_result,
  input  logic        i_alu_compare_result
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_op1_q, alu_op1_d;
  logic [31:0] alu_op2_q, alu_op2_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_res_q, rsp0_res_d;
  logic [31:0] rsp0_sh_q, rsp0_sh_d;
  logic        rsp0_cmp_q, rsp0_cmp_d;
  logic [31:0] rsp1_res_q, rsp1_res_d;
  logic [31:0] rsp1_sh_q, rsp1_sh_d;
  logic        rsp1_cmp_q, rsp1_cmp_d;
  logic        any_req;
  logic        pick;
  logic        hs;

`ifdef CPU_ALU_ARB_ROUND_ROBIN_EN
  logic        rr_q, rr_d;
  assign pick = (i_req0_valid & i_req1_valid) ? rr_q : i_req1_valid;
`else
  assign pick = i_req1_valid & ~i_req0_valid;
`endif

  assign any_req = i_req0_valid | i_req1_valid;
  // Ready is gated by reset so it reads 0 while reset is held.
  assign o_req0_ready = i_reset & (state_q == IDLE) & any_req & ~pick;
  assign o_req1_ready = i_reset & (state_q == IDLE) & any_req & pick;

  assign hs = grant_q ? (rsp1_valid_q & i_rsp1_ready)
                      : (rsp0_valid_q & i_rsp0_ready);

  assign o_alu_op            = alu_op_q;
  assign o_alu_op1           = alu_op1_q;
  assign o_alu_op2           = alu_op2_q;
  assign o_rsp0_valid        = rsp0_valid_q;
  assign o_rsp0_result       = rsp0_res_q;
  assign o_rsp0_shift_result = rsp0_sh_q;
  assign o_rsp0_compare      = rsp0_cmp_q;
  assign o_rsp1_valid        = rsp1_valid_q;
  assign o_rsp1_result       = rsp1_res_q;
  assign o_rsp1_shift_result = rsp1_sh_q;
  assign o_rsp1_compare      = rsp1_cmp_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    alu_op_d     = alu_op_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_res_d   = rsp0_res_q;
    rsp0_sh_d    = rsp0_sh_q;
    rsp0_cmp_d   = rsp0_cmp_q;
    rsp1_res_d   = rsp1_res_q;
    rsp1_sh_d    = rsp1_sh_q;
    rsp1_cmp_d   = rsp1_cmp_q;
`ifdef CPU_ALU_ARB_ROUND_ROBIN_EN
    rr_d         = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = EXEC;
          grant_d   = pick;
          alu_op_d  = pick ? i_req1_op  : i_req0_op;
          alu_op1_d = pick ? i_req1_op1 : i_req0_op1;
          alu_op2_d = pick ? i_req1_op2 : i_req0_op2;
        end
      end
      EXEC: begin
        state_d   = RESP;
        alu_op_d  = '0;
        alu_op1_d = '0;
        alu_op2_d = '0;
        if (grant_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_res_d   = i_alu_result;
          rsp1_sh_d    = i_alu_shift_result;
          rsp1_cmp_d   = i_alu_compare_result;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_res_d   = i_alu_result;
          rsp0_sh_d    = i_alu_shift_result;
          rsp0_cmp_d   = i_alu_compare_result;
        end
      end
      RESP: begin
        if (hs) begin
          state_d      = IDLE;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
`ifdef CPU_ALU_ARB_ROUND_ROBIN_EN
          rr_d         = ~grant_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_res_q   <= '0;
      rsp0_sh_q    <= '0;
      rsp0_cmp_q   <= 1'b0;
      rsp1_res_q   <= '0;
      rsp1_sh_q    <= '0;
      rsp1_cmp_q   <= 1'b0;
`ifdef CPU_ALU_ARB_ROUND_ROBIN_EN
      rr_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      alu_op_q     <= alu_op_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp0_sh_q    <= rsp0_sh_d;
      rsp0_cmp_q   <= rsp0_cmp_d;
      rsp1_res_q   <= rsp1_res_d;
      rsp1_sh_q    <= rsp1_sh_d;
      rsp1_cmp_q   <= rsp1_cmp_d;
`ifdef CPU_ALU_ARB_ROUND_ROBIN_EN
      rr_q         <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_alu_arbiter.sv
// Directed bench for cpu_alu_arbiter with a small behavioural ALU.
// Honours CPU_ALU_ARB_ROUND_ROBIN_EN when picking the contested winner.
module tb_cpu_alu_arbiter;

  localparam logic [3:0] OP_SIGNED_ADD         = 4'd0;
  localparam logic [3:0] OP_SHIFT_LEFT         = 4'd1;
  localparam logic [3:0] OP_UNSIGNED_LESS_THAN = 4'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 0, v1 = 0, r0, r1;
  logic [3:0]  op0 = 0, op1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        rv0, rv1, rr0 = 0, rr1 = 0;
  logic [31:0] res0, sh0, res1, sh1;
  logic        cmp0, cmp1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_res, alu_sh;
  logic        alu_cmp;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_sh  = alu_a << alu_b[4:0];
    alu_cmp = alu_a < alu_b;
    case (alu_op)
      OP_SIGNED_ADD:         alu_res = alu_a + alu_b;
      OP_SHIFT_LEFT:         alu_res = alu_sh;
      OP_UNSIGNED_LESS_THAN: alu_res = {31'd0, alu_cmp};
      default:               alu_res = alu_a ^ alu_b;
    endcase
  end

  cpu_alu_arbiter dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op(op0),
    .i_req0_op1(a0), .i_req0_op2(b0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op(op1),
    .i_req1_op1(a1), .i_req1_op2(b1),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp0_result(res0),
    .o_rsp0_shift_result(sh0), .o_rsp0_compare(cmp0),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr1), .o_rsp1_result(res1),
    .o_rsp1_shift_result(sh1), .o_rsp1_compare(cmp1),
    .o_alu_op(alu_op), .o_alu_op1(alu_a), .o_alu_op2(alu_b),
    .i_alu_result(alu_res), .i_alu_shift_result(alu_sh),
    .i_alu_compare_result(alu_cmp)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({r0, r1, rv0, rv1} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {r0, r1, rv0, rv1});
    end
    checks++;
    if ({res0, sh0, res1, sh1, cmp0, cmp1} !== 130'd0) begin
      failures++;
      $display("FAIL reset_results got=%h exp=0",
               {res0, sh0, res1, sh1, cmp0, cmp1});
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== 68'd0) begin
      failures++;
      $display("FAIL reset_alu got=%h exp=0", {alu_op, alu_a, alu_b});
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    step();
    v0 = 1; op0 = OP_SIGNED_ADD; a0 = 32'hFFFF_FFFF; b0 = 32'd2;
    #1;
    checks++;
    if ({r0, r1} !== 2'b10) begin
      failures++;
      $display("FAIL add_ready got=%b exp=10", {r0, r1});
    end
    step();
    v0 = 0;
    #1;
    checks++;
    if ({alu_op, alu_a, alu_b, rv0} !==
        {OP_SIGNED_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0}) begin
      failures++;
      $display("FAIL add_exec got=%h/%h/%h v=%b exp=0/ffffffff/2 v=0",
               alu_op, alu_a, alu_b, rv0);
    end
    step();
    #1;
    checks++;
    if ({rv0, res0, sh0, cmp0} !== {1'b1, 32'd1, 32'hFFFF_FFFC, 1'b0}) begin
      failures++;
      $display("FAIL add_resp got=%b/%h/%h/%b exp=1/00000001/fffffffc/0",
               rv0, res0, sh0, cmp0);
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== 68'd0) begin
      failures++;
      $display("FAIL add_alu_resp got=%h exp=0", {alu_op, alu_a, alu_b});
    end
    rr0 = 1;
    step();
    rr0 = 0;
    #1;
    checks++;
    if ({rv0, res0} !== {1'b0, 32'd1}) begin
      failures++;
      $display("FAIL add_hold got=%b/%h exp=0/00000001", rv0, res0);
    end
  endtask

  task automatic test_contention();
    step();
    v0 = 1; op0 = OP_SHIFT_LEFT; a0 = 32'd1; b0 = 32'd4;
    v1 = 1; op1 = OP_UNSIGNED_LESS_THAN; a1 = 32'd3; b1 = 32'd5;
    #1;
    checks++;
    if ({r0, r1} !== 2'b10) begin
      failures++;
      $display("FAIL cont_grant got=%b exp=10", {r0, r1});
    end
    step();
    v0 = 0;
    #1;
    checks++;
    if ({r1, alu_op} !== {1'b0, OP_SHIFT_LEFT}) begin
      failures++;
      $display("FAIL cont_exec got=%b/%h exp=0/1", r1, alu_op);
    end
    step();
    #1;
    checks++;
    if ({rv0, sh0, rv1} !== {1'b1, 32'h10, 1'b0}) begin
      failures++;
      $display("FAIL cont_rsp0 got=%b/%h/%b exp=1/00000010/0", rv0, sh0, rv1);
    end
    rr0 = 1;
    #1;
    checks++;
    if (r1 !== 1'b0) begin
      failures++;
      $display("FAIL cont_hs_noaccept got=%b exp=0", r1);
    end
    step();
    rr0 = 0;
    #1;
    checks++;
    if ({r0, r1} !== 2'b01) begin
      failures++;
      $display("FAIL cont_grant1 got=%b exp=01", {r0, r1});
    end
    step();
    v1 = 0;
    step();
    #1;
    checks++;
    if ({rv1, res1, cmp1, sh1} !== {1'b1, 32'd1, 1'b1, 32'h60}) begin
      failures++;
      $display("FAIL cont_rsp1 got=%b/%h/%b/%h exp=1/00000001/1/00000060",
               rv1, res1, cmp1, sh1);
    end
    checks++;
    if ({rv0, res0} !== {1'b0, 32'h10}) begin
      failures++;
      $display("FAIL cont_rsp0_held got=%b/%h exp=0/00000010", rv0, res0);
    end
  endtask

  task automatic test_hold_withdraw();
    for (int i = 0; i < 5; i++) begin
      step();
      v0 = (i == 0);
      op0 = OP_SIGNED_ADD; a0 = 32'd7; b0 = 32'd8;
      #1;
      checks++;
      if ({r0, r1, rv1, res1, alu_op} !== {3'b001, 32'd1, 4'd0}) begin
        failures++;
        $display("FAIL hold_%0d got=%b%b%b/%h/%h exp=001/00000001/0",
                 i, r0, r1, rv1, res1, alu_op);
      end
    end
    step();
    v0 = 0;
    rr1 = 1;
    step();
    rr1 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      checks++;
      if ({rv0, rv1, alu_op} !== 6'd0) begin
        failures++;
        $display("FAIL withdraw_%0d got=%b%b/%h exp=00/0", i, rv0, rv1, alu_op);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic w1;
`ifdef CPU_ALU_ARB_ROUND_ROBIN_EN
    w1 = 1'b1;
`else
    w1 = 1'b0;
`endif
    step();
    v0 = 1; op0 = OP_SIGNED_ADD; a0 = 32'd5; b0 = 32'd6;
    step();
    v0 = 0;
    step();
    rr0 = 1;
    step();
    rr0 = 0;
    v0 = 1; op0 = OP_SIGNED_ADD; a0 = 32'd10; b0 = 32'd20;
    v1 = 1; op1 = OP_SIGNED_ADD; a1 = 32'd100; b1 = 32'd1;
    #1;
    checks++;
    if ({r0, r1} !== {~w1, w1}) begin
      failures++;
      $display("FAIL b2b_grant got=%b exp=%b", {r0, r1}, {~w1, w1});
    end
    step();
    v0 = 0; v1 = 0;
    #1;
    checks++;
    if (alu_a !== (w1 ? 32'd100 : 32'd10)) begin
      failures++;
      $display("FAIL b2b_exec got=%h exp=%h", alu_a, w1 ? 32'd100 : 32'd10);
    end
    step();
    #1;
    checks++;
    if ({rv0, rv1} !== {~w1, w1}) begin
      failures++;
      $display("FAIL b2b_valid got=%b exp=%b", {rv0, rv1}, {~w1, w1});
    end
    checks++;
    if ((w1 ? res1 : res0) !== (w1 ? 32'd101 : 32'd30)) begin
      failures++;
      $display("FAIL b2b_result got=%h exp=%h",
               w1 ? res1 : res0, w1 ? 32'd101 : 32'd30);
    end
    rr0 = 1; rr1 = 1;
    step();
    rr0 = 0; rr1 = 0;
  endtask

  task automatic test_reset_mid_exec();
    step();
    v1 = 1; op1 = OP_SHIFT_LEFT; a1 = 32'd2; b1 = 32'd3;
    step();
    v1 = 0;
    #1;
    checks++;
    if (alu_op !== OP_SHIFT_LEFT) begin
      failures++;
      $display("FAIL mid_exec_op got=%h exp=1", alu_op);
    end
    v0 = 1;
    rst_n = 0;
    #1;
    checks++;
    if ({r0, r1, rv0, rv1, alu_op, alu_a, alu_b} !== 72'd0) begin
      failures++;
      $display("FAIL mid_exec_reset got=%b%b%b%b/%h/%h/%h exp=0",
               r0, r1, rv0, rv1, alu_op, alu_a, alu_b);
    end
    checks++;
    if ({res0, sh0, res1, sh1, cmp0, cmp1} !== 130'd0) begin
      failures++;
      $display("FAIL mid_exec_results got=%h exp=0",
               {res0, sh0, res1, sh1, cmp0, cmp1});
    end
    step();
    v0 = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      checks++;
      if ({rv0, rv1, alu_op} !== 6'd0) begin
        failures++;
        $display("FAIL post_reset_%0d got=%b%b/%h exp=00/0",
                 i, rv0, rv1, alu_op);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_reset();
    test_contention();
    test_hold_withdraw();
    test_back_to_back();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
